// File: rtl/alu_result_sequencer_if.sv
// Request, ALU-drive and result signals between the control unit, ALU and sequencer.
interface alu_result_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 op_valid;
  logic                 op_ready;
  logic [3:0]           op_code;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [WIDTH-1:0]     alu_y;
  logic [WIDTH-1:0]     alu_b;
  logic [14:0]          alu_ctl;
  logic [2*WIDTH-1:0]   alu_c;
  logic                 res_valid;
  logic                 res_ready;
  logic [WIDTH-1:0]     res_lo;
  logic [WIDTH-1:0]     res_hi;
  logic                 res_hilo;
  logic                 res_err;

  // Control unit / ALU side
  modport master (
    output op_valid, op_code, op_a, op_b, alu_c, res_ready,
    input  op_ready, alu_y, alu_b, alu_ctl, res_valid, res_lo, res_hi, res_hilo, res_err
  );

  // Sequencer side
  modport slave (
    input  op_valid, op_code, op_a, op_b, alu_c, res_ready,
    output op_ready, alu_y, alu_b, alu_ctl, res_valid, res_lo, res_hi, res_hilo, res_err
  );
endinterface

// File: rtl/alu_result_sequencer.sv
// Issues one ALU operation per request, holds op-select for the op's latency,
// captures the 2*WIDTH result into Z and presents it over a result handshake.
module alu_result_sequencer #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned DEF_CYCLES    = 1,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input logic                   clk,
  input logic                   clr_n,
  alu_result_sequencer_if.slave bus
);

  localparam int unsigned MAX_CYCLES = (MULDIV_CYCLES > DEF_CYCLES) ? MULDIV_CYCLES : DEF_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned CTL_W      = 15;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t               state_q,    state_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic                 op_ready_q, op_ready_d;
  logic [CTL_W-1:0]     ctl_q,      ctl_d;
  logic [WIDTH-1:0]     y_q,        y_d;
  logic [WIDTH-1:0]     b_q,        b_d;
  logic [2*WIDTH-1:0]   z_q,        z_d;
  logic                 valid_q,    valid_d;
  logic                 hilo_q,     hilo_d;
  logic                 err_q,      err_d;
  logic                 muldiv_q,   muldiv_d;

  logic                 accept_c;
  logic                 is_muldiv_c;
  logic                 req_err_c;

  assign accept_c    = bus.op_valid && op_ready_q;
  assign is_muldiv_c = (bus.op_code == 4'h6) || (bus.op_code == 4'h7);
  assign req_err_c   = ((bus.op_code == 4'h7) && (bus.op_b == '0)) || (bus.op_code == 4'hF);

  // State and output registers; reset discards any in-flight result
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_ready_q <= 1'b1;
      ctl_q      <= '0;
      y_q        <= '0;
      b_q        <= '0;
      z_q        <= '0;
      valid_q    <= 1'b0;
      hilo_q     <= 1'b0;
      err_q      <= 1'b0;
      muldiv_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_ready_q <= op_ready_d;
      ctl_q      <= ctl_d;
      y_q        <= y_d;
      b_q        <= b_d;
      z_q        <= z_d;
      valid_q    <= valid_d;
      hilo_q     <= hilo_d;
      err_q      <= err_d;
      muldiv_q   <= muldiv_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_ready_d = op_ready_q;
    ctl_d      = ctl_q;
    y_d        = y_q;
    b_d        = b_q;
    z_d        = z_q;
    valid_d    = valid_q;
    hilo_d     = hilo_q;
    err_d      = err_q;
    muldiv_d   = muldiv_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          y_d        = bus.op_a;
          b_d        = bus.op_b;
          op_ready_d = 1'b0;
          muldiv_d   = is_muldiv_c;
          cnt_d      = is_muldiv_c ? CNT_W'(MULDIV_CYCLES - 1) : CNT_W'(DEF_CYCLES - 1);
          if (req_err_c) begin
            // Illegal request: report error without driving the ALU
            z_d     = '0;
            err_d   = 1'b1;
            hilo_d  = 1'b0;
            valid_d = 1'b1;
            state_d = RESP;
          end else begin
            ctl_d   = CTL_W'(1) << bus.op_code;
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        if (cnt_q == '0) begin
          z_d     = bus.alu_c;
          hilo_d  = muldiv_q;
          err_d   = 1'b0;
          ctl_d   = '0;
          valid_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        if (valid_q && bus.res_ready) begin
          valid_d    = 1'b0;
          op_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.op_ready  = op_ready_q;
  assign bus.alu_y     = y_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_ctl   = ctl_q;
  assign bus.res_valid = valid_q;
  assign bus.res_lo    = z_q[WIDTH-1:0];
  assign bus.res_hi    = z_q[2*WIDTH-1:WIDTH];
  assign bus.res_hilo  = hilo_q;
  assign bus.res_err   = err_q;

endmodule
